// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM bus sequencer: FSM encoding, transceiver
// direction constants and wait-counter width.
package ram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      ACCESS  = 2'd2,
      RECOVER = 2'd3
   } state_t;

   localparam logic DIR_A_TO_B = 1'b1;
   localparam logic DIR_B_TO_A = 1'b0;

   localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/ram_bus_sequencer.sv
// Sequences single RAM accesses through a '245-style transceiver with
// guaranteed bus turnaround; all outputs are registered.
module ram_bus_sequencer
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata,
   output logic              ack,
   output logic              busy,
   input  logic [7:0]        bus_a_in,
   output logic [7:0]        bus_a_out,
   output logic              bus_a_oe,
   output logic              xcvr_oe_n,
   output logic              xcvr_dir,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_ce_n,
   output logic              ram_we_n,
   output logic              ram_oe_n
);

   generate
      if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
         $error("WAIT_STATES must be in 0..15");
      end
   endgenerate

   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_STATES);

   state_t            state, next_state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              lat_we;
   logic              we_eff;
   logic              ack_d, busy_d, bus_a_oe_d, xcvr_oe_n_d;
   logic              ram_ce_n_d, ram_we_n_d, ram_oe_n_d;

   // State register; outputs are registered from their next-state decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         lat_we    <= 1'b0;
         rdata     <= '0;
         ack       <= 1'b0;
         busy      <= 1'b0;
         bus_a_out <= '0;
         bus_a_oe  <= 1'b0;
         xcvr_oe_n <= 1'b1;
         xcvr_dir  <= DIR_B_TO_A;
         ram_addr  <= '0;
         ram_ce_n  <= 1'b1;
         ram_we_n  <= 1'b1;
         ram_oe_n  <= 1'b1;
      end else begin
         state    <= next_state;
         wait_cnt <= (state == ACCESS && next_state == ACCESS) ? wait_cnt + WAIT_W'(1) : '0;
         // Direction only moves on entry to SETUP, while the transceiver is disabled.
         if (state == IDLE && req) begin
            lat_we   <= we;
            ram_addr <= addr;
            xcvr_dir <= we ? DIR_A_TO_B : DIR_B_TO_A;
            if (we) bus_a_out <= wdata;
         end
         if (state == ACCESS && next_state == RECOVER && !lat_we) rdata <= bus_a_in;
         ack       <= ack_d;
         busy      <= busy_d;
         bus_a_oe  <= bus_a_oe_d;
         xcvr_oe_n <= xcvr_oe_n_d;
         ram_ce_n  <= ram_ce_n_d;
         ram_we_n  <= ram_we_n_d;
         ram_oe_n  <= ram_oe_n_d;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (req) next_state = SETUP;
         SETUP:   next_state = ACCESS;
         ACCESS:  if (wait_cnt == LAST_WAIT) next_state = RECOVER;
         RECOVER: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // The access type for the upcoming cycle comes from the live input only when it is being accepted.
   always_comb begin
      we_eff      = (state == IDLE) ? we : lat_we;
      ack_d       = 1'b0;
      busy_d      = 1'b0;
      bus_a_oe_d  = 1'b0;
      xcvr_oe_n_d = 1'b1;
      ram_ce_n_d  = 1'b1;
      ram_we_n_d  = 1'b1;
      ram_oe_n_d  = 1'b1;
      case (next_state)
         SETUP: begin
            busy_d     = 1'b1;
            ram_ce_n_d = 1'b0;
            bus_a_oe_d = we_eff;
         end
         ACCESS: begin
            busy_d      = 1'b1;
            ram_ce_n_d  = 1'b0;
            xcvr_oe_n_d = 1'b0;
            if (we_eff) begin
               ram_we_n_d = 1'b0;
               bus_a_oe_d = 1'b1;
            end else begin
               ram_oe_n_d = 1'b0;
            end
         end
         RECOVER: begin
            busy_d     = 1'b1;
            ack_d      = 1'b1;
            ram_ce_n_d = 1'b0;
            if (we_eff) begin
               xcvr_oe_n_d = 1'b0;
               bus_a_oe_d  = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ram_bus_sequencer.sv
// Self-checking bench: a pin-level RAM/transceiver model feeds the DUT and a
// transaction-level memory image predicts read data and timing.
module tb_ram_bus_sequencer;

   localparam int ADDR_W = 4;
   localparam int WS     = 1;
   localparam int LAT    = WS + 3;
   localparam int STROBE = WS + 1;

   logic              clk;
   logic              rst;
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        wdata;
   logic [7:0]        rdata;
   logic              ack;
   logic              busy;
   logic [7:0]        bus_a_in;
   logic [7:0]        bus_a_out;
   logic              bus_a_oe;
   logic              xcvr_oe_n;
   logic              xcvr_dir;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_ce_n;
   logic              ram_we_n;
   logic              ram_oe_n;

   ram_bus_sequencer #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ack(ack), .busy(busy), .bus_a_in(bus_a_in),
      .bus_a_out(bus_a_out), .bus_a_oe(bus_a_oe), .xcvr_oe_n(xcvr_oe_n),
      .xcvr_dir(xcvr_dir), .ram_addr(ram_addr), .ram_ce_n(ram_ce_n),
      .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [7:0] ram     [16];
   logic [7:0] ref_mem [16];
   logic [7:0] noise;

   // Physical side: RAM drives port A only through an enabled B->A transceiver.
   always @(posedge clk) noise <= 8'($urandom);
   assign bus_a_in = (!ram_ce_n && !ram_oe_n && !xcvr_oe_n && xcvr_dir == 1'b0) ? ram[ram_addr] : noise;
   always @(posedge clk)
      if (!ram_ce_n && !ram_we_n && !xcvr_oe_n && xcvr_dir && bus_a_oe) ram[ram_addr] <= bus_a_out;

   // Continuous bus-safety monitor.
   bit   mon_en = 1'b0;
   logic rst_q;
   logic prev_oe_n, prev_dir;
   always @(posedge clk) rst_q <= rst;
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (!ram_we_n && !ram_oe_n) begin
            failures++;
            $display("FAIL strobe_overlap: got we_n=%b oe_n=%b expected not both low", ram_we_n, ram_oe_n);
         end
         if (!rst_q) begin
            checks++;
            if (xcvr_dir !== prev_dir && (!xcvr_oe_n || !prev_oe_n)) begin
               failures++;
               $display("FAIL dir_turnaround: got dir %b->%b with oe_n prev=%b cur=%b expected oe_n high", prev_dir, xcvr_dir, prev_oe_n, xcvr_oe_n);
            end
         end
         checks++;
         if (!xcvr_oe_n && xcvr_dir == 1'b0 && bus_a_oe) begin
            failures++;
            $display("FAIL read_contention: got bus_a_oe=1 with transceiver driving A expected bus_a_oe=0");
         end
      end
      prev_oe_n = xcvr_oe_n;
      prev_dir  = xcvr_dir;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one request and records what the pins did until ack (bounded).
   task automatic run_txn(input logic t_we, input logic [ADDR_W-1:0] t_addr, input logic [7:0] t_wdata,
                          input bit keep_req, input bit scramble,
                          output int setup_k, output int ack_k, output int we_low, output int oe_low,
                          output logic [ADDR_W-1:0] s_addr, output logic s_dir, output bit data_ok,
                          output logic [7:0] rd_at_ack);
      req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
      setup_k = -1; ack_k = -1; we_low = 0; oe_low = 0; data_ok = 1'b1;
      s_addr = '0; s_dir = 1'b0; rd_at_ack = '0;
      for (int k = 1; k <= 40 && ack_k < 0; k++) begin
         tick();
         if (busy && setup_k < 0) begin
            setup_k = k;
            s_addr  = ram_addr;
            s_dir   = xcvr_dir;
         end
         if (!ram_we_n) begin
            we_low++;
            if (bus_a_out !== t_wdata) data_ok = 1'b0;
         end
         if (!ram_oe_n) oe_low++;
         if (ack) begin
            ack_k     = k;
            rd_at_ack = rdata;
            if (!keep_req) req = 1'b0;
         end else if (scramble && busy) begin
            addr  = ADDR_W'($urandom);
            wdata = 8'($urandom);
            we    = 1'($urandom);
         end
      end
   endtask

   int sk, ak, wl, ol;
   logic [ADDR_W-1:0] sa;
   logic sd;
   bit   dok;
   logic [7:0] rda;

   task automatic test_reset();
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      tick(); tick();
      checks++; if (rdata !== 8'h00)   begin failures++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
      checks++; if (ack !== 1'b0)      begin failures++; $display("FAIL reset_ack: got %b expected 0", ack); end
      checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (bus_a_out !== 8'h00) begin failures++; $display("FAIL reset_bus_a_out: got %h expected 00", bus_a_out); end
      checks++; if (bus_a_oe !== 1'b0) begin failures++; $display("FAIL reset_bus_a_oe: got %b expected 0", bus_a_oe); end
      checks++; if (xcvr_oe_n !== 1'b1) begin failures++; $display("FAIL reset_xcvr_oe_n: got %b expected 1", xcvr_oe_n); end
      checks++; if (xcvr_dir !== 1'b0) begin failures++; $display("FAIL reset_xcvr_dir: got %b expected 0", xcvr_dir); end
      checks++; if (ram_addr !== '0)   begin failures++; $display("FAIL reset_ram_addr: got %h expected 0", ram_addr); end
      checks++; if (ram_ce_n !== 1'b1) begin failures++; $display("FAIL reset_ram_ce_n: got %b expected 1", ram_ce_n); end
      checks++; if (ram_we_n !== 1'b1) begin failures++; $display("FAIL reset_ram_we_n: got %b expected 1", ram_we_n); end
      checks++; if (ram_oe_n !== 1'b1) begin failures++; $display("FAIL reset_ram_oe_n: got %b expected 1", ram_oe_n); end
      rst = 1'b0;
      mon_en = 1'b1;
   endtask

   task automatic test_write();
      run_txn(1'b1, 4'h3, 8'hA5, 1'b0, 1'b0, sk, ak, wl, ol, sa, sd, dok, rda);
      ref_mem[3] = 8'hA5;
      checks++; if (sk !== 1)          begin failures++; $display("FAIL write_setup_cycle: got %0d expected 1", sk); end
      checks++; if (sa !== 4'h3)       begin failures++; $display("FAIL write_setup_addr: got %h expected 3", sa); end
      checks++; if (sd !== 1'b1)       begin failures++; $display("FAIL write_setup_dir: got %b expected 1", sd); end
      checks++; if (wl !== STROBE)     begin failures++; $display("FAIL write_we_low: got %0d expected %0d", wl, STROBE); end
      checks++; if (ol !== 0)          begin failures++; $display("FAIL write_oe_low: got %0d expected 0", ol); end
      checks++; if (dok !== 1'b1)      begin failures++; $display("FAIL write_bus_data: got mismatch expected A5 on bus"); end
      checks++; if (ak !== LAT)        begin failures++; $display("FAIL write_latency: got %0d expected %0d", ak, LAT); end
      checks++; if (ram[3] !== ref_mem[3]) begin failures++; $display("FAIL write_ram: got %h expected %h", ram[3], ref_mem[3]); end
      tick();
      checks++; if ({ack, busy, ram_ce_n, xcvr_oe_n, bus_a_oe} !== 5'b00110) begin
         failures++; $display("FAIL write_release: got ack,busy,ce_n,oe_n,a_oe=%b expected 00110", {ack, busy, ram_ce_n, xcvr_oe_n, bus_a_oe});
      end
   endtask

   task automatic test_read();
      ram[3] = 8'h5A; ref_mem[3] = 8'h5A;
      run_txn(1'b0, 4'h3, 8'h00, 1'b0, 1'b0, sk, ak, wl, ol, sa, sd, dok, rda);
      checks++; if (ol !== STROBE)     begin failures++; $display("FAIL read_oe_low: got %0d expected %0d", ol, STROBE); end
      checks++; if (wl !== 0)          begin failures++; $display("FAIL read_we_low: got %0d expected 0", wl); end
      checks++; if (sd !== 1'b0)       begin failures++; $display("FAIL read_dir: got %b expected 0", sd); end
      checks++; if (ak - sk + 1 !== LAT) begin failures++; $display("FAIL read_latency: got %0d expected %0d", ak - sk + 1, LAT); end
      checks++; if (rda !== 8'h5A)     begin failures++; $display("FAIL read_data: got %h expected 5a", rda); end
      tick(); tick(); tick();
      checks++; if (rdata !== 8'h5A)   begin failures++; $display("FAIL read_hold: got %h expected 5a", rdata); end
   endtask

   task automatic test_back_to_back();
      run_txn(1'b1, 4'h1, 8'h11, 1'b1, 1'b0, sk, ak, wl, ol, sa, sd, dok, rda);
      ref_mem[1] = 8'h11;
      run_txn(1'b0, 4'h1, 8'h00, 1'b0, 1'b0, sk, ak, wl, ol, sa, sd, dok, rda);
      checks++; if (sk !== 2)          begin failures++; $display("FAIL b2b_setup_gap: got %0d expected 2", sk); end
      checks++; if (sd !== 1'b0)       begin failures++; $display("FAIL b2b_dir: got %b expected 0", sd); end
      checks++; if (rda !== ref_mem[1]) begin failures++; $display("FAIL b2b_data: got %h expected %h", rda, ref_mem[1]); end
      tick();
   endtask

   task automatic test_ignored_req();
      logic [ADDR_W-1:0] ta;
      logic [7:0]        td;
      int                extra;
      ta = ADDR_W'($urandom); td = 8'($urandom);
      run_txn(1'b1, ta, td, 1'b0, 1'b1, sk, ak, wl, ol, sa, sd, dok, rda);
      ref_mem[ta] = td;
      checks++; if (sa !== ta)         begin failures++; $display("FAIL ignored_addr: got %h expected %h", sa, ta); end
      checks++; if (dok !== 1'b1 || wl !== STROBE) begin failures++; $display("FAIL ignored_data: got ok=%b we_low=%0d expected 1,%0d", dok, wl, STROBE); end
      extra = 0;
      for (int i = 0; i < 6; i++) begin tick(); if (ack) extra++; end
      checks++; if (extra !== 0)       begin failures++; $display("FAIL ignored_extra_ack: got %0d expected 0", extra); end
      run_txn(1'b0, ta, 8'h00, 1'b0, 1'b0, sk, ak, wl, ol, sa, sd, dok, rda);
      checks++; if (rda !== ref_mem[ta]) begin failures++; $display("FAIL ignored_readback: got %h expected %h", rda, ref_mem[ta]); end
   endtask

   task automatic test_random();
      logic              rw;
      logic [ADDR_W-1:0] ra;
      logic [7:0]        rd;
      int                exp_sk;
      tick(); tick();
      exp_sk = 1;
      for (int n = 0; n < 24; n++) begin
         rw = 1'($urandom); ra = ADDR_W'($urandom); rd = 8'($urandom);
         run_txn(rw, ra, rd, 1'($urandom), 1'b0, sk, ak, wl, ol, sa, sd, dok, rda);
         checks++; if (sk !== exp_sk || ak - sk + 1 !== LAT) begin
            failures++; $display("FAIL rand_timing[%0d]: got setup=%0d lat=%0d expected %0d,%0d", n, sk, ak - sk + 1, exp_sk, LAT);
         end
         if (rw) begin
            ref_mem[ra] = rd;
            checks++; if (wl !== STROBE || !dok) begin failures++; $display("FAIL rand_write[%0d]: got we_low=%0d ok=%b expected %0d,1", n, wl, dok, STROBE); end
         end else begin
            checks++; if (rda !== ref_mem[ra]) begin failures++; $display("FAIL rand_read[%0d] addr %h: got %h expected %h", n, ra, rda, ref_mem[ra]); end
         end
         exp_sk = 2;
      end
      req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      bit found;
      int extra;
      ram[7] = 8'hC3; ref_mem[7] = 8'hC3;
      run_txn(1'b0, 4'h7, 8'h00, 1'b0, 1'b0, sk, ak, wl, ol, sa, sd, dok, rda);
      tick();
      req = 1'b1; we = 1'b0; addr = 4'h7;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (!ram_oe_n) found = 1'b1;
      end
      checks++; if (!found)            begin failures++; $display("FAIL midrst_reach_access: got no ACCESS expected ACCESS within 10 cycles"); end
      checks++; if (rdata !== 8'hC3)   begin failures++; $display("FAIL midrst_pre_rdata: got %h expected c3", rdata); end
      req = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if ({busy, ack, ram_ce_n, ram_we_n, ram_oe_n, xcvr_oe_n, bus_a_oe} !== 7'b0011110) begin
         failures++; $display("FAIL midrst_outputs: got %b expected 0011110", {busy, ack, ram_ce_n, ram_we_n, ram_oe_n, xcvr_oe_n, bus_a_oe});
      end
      checks++; if (rdata !== 8'h00)   begin failures++; $display("FAIL midrst_rdata: got %h expected 00", rdata); end
      extra = 0;
      for (int i = 0; i < 6; i++) begin tick(); if (ack || busy) extra++; end
      checks++; if (extra !== 0)       begin failures++; $display("FAIL midrst_no_ack: got %0d active cycles expected 0", extra); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         ram[i]     = 8'($urandom);
         ref_mem[i] = ram[i];
      end
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_ignored_req();
      test_random();
      test_reset_mid();
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
